// File: rtl/sram_pkg.sv
// Shared definitions for the single-port byte-masked SRAM and its March C- self-test engine:
// engine state codes, March element encoding and test background constants.
package sram_pkg;

    typedef logic [3:0] mbist_state_t;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_M0    = 4'd1;
    localparam logic [3:0] ST_M1    = 4'd2;
    localparam logic [3:0] ST_M2    = 4'd3;
    localparam logic [3:0] ST_M3    = 4'd4;
    localparam logic [3:0] ST_M4    = 4'd5;
    localparam logic [3:0] ST_M5    = 4'd6;
    localparam logic [3:0] ST_CHECK = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    // Background bit, replicated across the whole word by the engine.
    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONE  = 1'b1;

    typedef struct packed {
        logic down;
        logic do_read;
        logic do_write;
        logic rd_bg;
        logic wr_bg;
    } march_elem_t;

    // March C-: M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0.
    function automatic march_elem_t march_elem(input mbist_state_t st);
        march_elem_t e;
        e = '0;
        case (st)
            ST_M0:   e = '{1'b0, 1'b0, 1'b1, BG_ZERO, BG_ZERO};
            ST_M1:   e = '{1'b0, 1'b1, 1'b1, BG_ZERO, BG_ONE};
            ST_M2:   e = '{1'b0, 1'b1, 1'b1, BG_ONE,  BG_ZERO};
            ST_M3:   e = '{1'b1, 1'b1, 1'b1, BG_ZERO, BG_ONE};
            ST_M4:   e = '{1'b1, 1'b1, 1'b1, BG_ONE,  BG_ZERO};
            ST_M5:   e = '{1'b1, 1'b1, 1'b0, BG_ZERO, BG_ZERO};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_mbist_engine.sv
// March C- sequencer: issues one memory operation per cycle and exposes its state for debug.
// Built only when RM_SRAM_MBIST_EN is defined.
module sram_mbist_engine
    import sram_pkg::*;
#(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output mbist_state_t            state,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    we,
    output logic                    re,
    output logic [P_DATA_WIDTH-1:0] wdata,
    output logic [P_DATA_WIDTH-1:0] exp_data
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    mbist_state_t            state_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic                    phase_q;
    logic                    rd_pend_q;

    march_elem_t elem;
    march_elem_t next_elem;
    logic        in_march;
    logic        start_ok;
    logic        addr_last;
    logic        at_end;

    always_comb begin
        elem      = march_elem(state_q);
        next_elem = march_elem(state_q + 4'd1);
        in_march  = (state_q >= ST_M0) && (state_q <= ST_M5);
        start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        // Two-op elements spend a read slot (phase 0) then a write slot (phase 1) per address.
        re        = in_march && elem.do_read && (!elem.do_write || !phase_q);
        we        = in_march && elem.do_write && (!elem.do_read || phase_q);
        addr_last = !(elem.do_read && elem.do_write) || phase_q;
        at_end    = elem.down ? (addr_q == '0) : (addr_q == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= re;
            if (start_ok) begin
                state_q <= ST_M0;
                addr_q  <= '0;
                phase_q <= 1'b0;
            end else if (in_march) begin
                if (!addr_last) begin
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (at_end) begin
                        state_q <= state_q + 4'd1;
                        addr_q  <= next_elem.down ? '1 : '0;
                    end else begin
                        addr_q <= elem.down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end else if ((state_q == ST_CHECK) && !rd_pend_q) begin
                // Hold CHECK until the final read has been compared.
                state_q <= ST_DONE;
            end
        end
    end

    assign state    = state_q;
    assign addr     = addr_q;
    assign wdata    = {P_DATA_WIDTH{elem.wr_bg}};
    assign exp_data = {P_DATA_WIDTH{elem.rd_bg}};

endmodule

// File: rtl/sram_1p_bm_mbist.sv
// Single-port SRAM with per-bit write mask and registered read data, plus an optional
// March C- self-test that is compiled in when RM_SRAM_MBIST_EN is defined.
module sram_1p_bm_mbist
    import sram_pkg::*;
#(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    A_CLK,
    input  logic                    A_RESET_N,
    input  logic                    A_MEN,
    input  logic                    A_WEN,
    input  logic                    A_REN,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [P_DATA_WIDTH-1:0] A_DIN,
    input  logic [P_DATA_WIDTH-1:0] A_BM,
    output logic [P_DATA_WIDTH-1:0] A_DOUT,
    input  logic                    A_BIST_START,
    output logic                    A_BIST_BUSY,
    output logic                    A_BIST_DONE,
    output logic                    A_BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR
);

    localparam int DEPTH = 1 << P_ADDR_WIDTH;

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    mbist_state_t            bist_state;
    logic                    bist_busy;
    logic                    func_we;
    logic                    func_re;
    logic                    mem_we;
    logic [P_ADDR_WIDTH-1:0] mem_addr;
    logic [P_DATA_WIDTH-1:0] mem_wdata;
    logic [P_DATA_WIDTH-1:0] mem_bm;

    assign bist_busy = (bist_state != ST_IDLE) && (bist_state != ST_DONE);
    // A combined write+read request performs only the write.
    assign func_we   = A_MEN && !bist_busy && A_WEN;
    assign func_re   = A_MEN && !bist_busy && A_REN && !A_WEN;

`ifdef RM_SRAM_MBIST_EN
    logic                    bist_we;
    logic                    bist_re;
    logic [P_ADDR_WIDTH-1:0] bist_addr;
    logic [P_DATA_WIDTH-1:0] bist_wdata;
    logic [P_DATA_WIDTH-1:0] bist_exp;
    logic [P_DATA_WIDTH-1:0] bist_rd_q;
    logic [P_DATA_WIDTH-1:0] bist_exp_q;
    logic [P_ADDR_WIDTH-1:0] cmp_addr_q;
    logic                    cmp_vld_q;
    logic                    fail_q;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q;
    logic                    start_ok;

    sram_mbist_engine #(
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_engine (
        .clk      (A_CLK),
        .rst_n    (A_RESET_N),
        .start    (A_BIST_START),
        .state    (bist_state),
        .addr     (bist_addr),
        .we       (bist_we),
        .re       (bist_re),
        .wdata    (bist_wdata),
        .exp_data (bist_exp)
    );

    assign start_ok  = A_BIST_START && !bist_busy;
    assign mem_we    = bist_busy ? bist_we    : func_we;
    assign mem_addr  = bist_busy ? bist_addr  : A_ADDR;
    assign mem_wdata = bist_busy ? bist_wdata : A_DIN;
    assign mem_bm    = bist_busy ? '1         : A_BM;

    always_ff @(posedge A_CLK) begin
        if (bist_re) begin
            bist_rd_q  <= mem[bist_addr];
            bist_exp_q <= bist_exp;
            cmp_addr_q <= bist_addr;
        end
    end

    // Compare lands one cycle after each read; only the first mismatch address is kept.
    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            cmp_vld_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            cmp_vld_q <= bist_re;
            if (start_ok) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
            end else if (cmp_vld_q && (bist_rd_q != bist_exp_q) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
            end
        end
    end

    assign A_BIST_BUSY      = bist_busy;
    assign A_BIST_DONE      = (bist_state == ST_DONE);
    assign A_BIST_FAIL      = fail_q;
    assign A_BIST_FAIL_ADDR = fail_addr_q;
`else
    logic unused_bist_start;

    assign unused_bist_start = A_BIST_START;
    assign bist_state        = ST_IDLE;
    assign mem_we            = func_we;
    assign mem_addr          = A_ADDR;
    assign mem_wdata         = A_DIN;
    assign mem_bm            = A_BM;

    assign A_BIST_BUSY       = 1'b0;
    assign A_BIST_DONE       = 1'b0;
    assign A_BIST_FAIL       = 1'b0;
    assign A_BIST_FAIL_ADDR  = '0;
`endif

    // The array itself is never reset.
    always_ff @(posedge A_CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= (mem[mem_addr] & ~mem_bm) | (mem_wdata & mem_bm);
        end
    end

    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            A_DOUT <= '0;
        end else if (func_re) begin
            A_DOUT <= mem[A_ADDR];
        end
    end

endmodule

// File: doc/sram_1p_bm_mbist.md
SRAM_1P_BM_MBIST -- requirements
Module: sram_1p_bm_mbist

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 64, word width in bits (8..256).
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 8, address width; depth = 2**P_ADDR_WIDTH words.
REQ-003 SHALL have port A_CLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port A_RESET_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports A_MEN / A_WEN / A_REN  in  1 each  macro enable, write enable, read enable.
REQ-006 SHALL have port A_ADDR  in  P_ADDR_WIDTH  word address.
REQ-007 SHALL have ports A_DIN and A_BM  in  P_DATA_WIDTH each  write data; per-bit write mask, 1 = write bit.
REQ-008 SHALL have port A_DOUT  out  P_DATA_WIDTH  registered read data.
REQ-009 SHALL have port A_BIST_START  in  1  single-cycle pulse that launches the self-test.
REQ-010 SHALL have ports A_BIST_BUSY / A_BIST_DONE / A_BIST_FAIL  out  1 each  test running; test finished (sticky); mismatch seen (sticky).
REQ-011 SHALL have port A_BIST_FAIL_ADDR  out  P_ADDR_WIDTH  address of first mismatch.

Function
REQ-012 SHALL perform a functional access on a rising edge only when A_MEN=1 and A_BIST_BUSY=0.
REQ-013 SHALL update bit i of mem[A_ADDR] to A_DIN[i] on a write for each i where A_BM[i]=1; other bits are unchanged.
REQ-014 SHALL present mem[A_ADDR] on A_DOUT one cycle after a read edge; A_DOUT holds its value in every cycle without a read.
REQ-015 SHALL perform the write only, with A_DOUT held, when A_WEN=1 and A_REN=1 together.
REQ-016 SHALL run March C- on the array using engine states IDLE, M0..M5, CHECK and DONE.
REQ-017 SHALL execute the March C- elements as M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0.
REQ-018 SHALL use all-zero or all-one words as the test background, with BM forced to all-ones.
REQ-019 SHALL issue exactly one memory operation per cycle.
REQ-020 SHALL wrap the address counter from max to 0 (up elements) or from 0 to max (down elements), and advance to the next element at the wrap.
REQ-021 SHALL compare each read result one cycle after the read, in the pipeline slot.
REQ-022 SHALL, on the first mismatch, set A_BIST_FAIL and capture A_BIST_FAIL_ADDR; later mismatches do not change the captured address.
REQ-023 SHALL take exactly 10*2**P_ADDR_WIDTH + 2 cycles from the A_BIST_START edge to A_BIST_DONE rising (for example, 2562 cycles at the default depth).
REQ-024 SHALL raise A_BIST_BUSY on the edge after the start pulse and drop it on the same edge that raises A_BIST_DONE.
REQ-025 SHALL ignore A_BIST_START while A_BIST_BUSY=1.
REQ-026 SHALL, on A_BIST_START in DONE, clear DONE, FAIL and FAIL_ADDR and restart the test.
REQ-027 SHALL ignore functional inputs while the test runs, leave A_DOUT frozen, and leave the array all-zero after the test completes.

Reset
REQ-028 SHALL, while A_RESET_N=0, force A_DOUT=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0 and engine state IDLE, independent of A_CLK.
REQ-029 SHALL abort a running test on reset; the array contents are then undefined.
REQ-030 SHALL never initialise array contents by reset.
REQ-031 SHALL accept the first access on the first rising edge after A_RESET_N deasserts.

Configuration
REQ-032 SHALL build the March engine, the compare logic and the BIST ports' drivers only when macro RM_SRAM_MBIST_EN is defined.
REQ-033 SHALL, without RM_SRAM_MBIST_EN, tie A_BIST_BUSY/DONE/FAIL/FAIL_ADDR to 0, ignore A_BIST_START, and keep functional access unconditional.

Structure
REQ-034 SHALL place the engine-state enum, the March element encoding and the background constants in shared package sram_pkg.
REQ-035 SHALL implement the March engine as sub-module sram_mbist_engine, which drives the address, write enable, data and expected data to the top.
REQ-036 SHALL keep the array, the port mux and the read register in sram_1p_bm_mbist.

Verification
REQ-037 SHALL cover this scenario: write addr 0x12, DIN=all ones, BM=0x00000000FFFFFFFF, over a prior all-zero word; read 0x12 -> A_DOUT=0x00000000FFFFFFFF one cycle later.
REQ-038 SHALL cover this scenario: WEN=REN=1 at addr 5 -> word written, A_DOUT unchanged; following read of addr 5 -> new data.
REQ-039 SHALL cover this scenario: START on a fault-free array -> BUSY for 2562 cycles, DONE=1, FAIL=0, all 256 words read 0 afterwards.
REQ-040 SHALL cover this scenario: bit 3 of addr 0x47 forced stuck-at-1 during the test -> FAIL=1, FAIL_ADDR=0x47, DONE after 2562 cycles.
REQ-041 SHALL cover this scenario: START, then reset asserted at cycle 700 -> all outputs 0, IDLE; a new START completes normally.
REQ-042 SHALL cover this scenario: second START pulse while BUSY -> ignored, completion still at cycle 2562; START after DONE -> flags cleared, test rerun.
